// File: rtl/router_slave_arbiter_if.sv
// Request/grant bundle between the masters of one router slave port and its arbiter.
interface router_slave_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] last;
    logic                   slv_ready;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic                   timeout_err;

    modport master (
        output req, last, slv_ready,
        input  grant, grant_idx, grant_valid, timeout_err
    );

    modport slave (
        input  req, last, slv_ready,
        output grant, grant_idx, grant_valid, timeout_err
    );
endinterface

// File: rtl/router_slave_arbiter.sv
// Round-robin arbiter for one router slave port: grant held per transaction,
// watchdog forces release when the slave stalls too long.
module router_slave_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    router_slave_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic {IDLE, OWN} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] cand;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic                   done, abort, tmo;

    // While owned, the current owner is masked out so a release hands off to someone else.
    assign cand = (state_q == OWN) ? (bus.req & ~grant_q) : bus.req;

    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            j = (int'(ptr_q) + k) % NUM_MASTERS;
            if (!win_found && cand[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    assign done  = bus.req[idx_q] & bus.last[idx_q] & bus.slv_ready;
    assign abort = ~bus.req[idx_q];
    assign tmo   = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_WIDTH'(TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    state_d = OWN;
                    grant_d = NUM_MASTERS'(1) << win_idx;
                    idx_d   = win_idx;
                    ptr_d   = win_idx;
                    valid_d = 1'b1;
                end
            end
            OWN: begin
                if (done || abort || tmo) begin
                    // Completion or abort outrank a coincident timeout.
                    err_d = tmo & ~done & ~abort;
                    cnt_d = '0;
                    if (win_found) begin
                        grant_d = NUM_MASTERS'(1) << win_idx;
                        idx_d   = win_idx;
                        ptr_d   = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (bus.slv_ready) begin
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(NUM_MASTERS - 1);
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout_err = err_q;
endmodule
